// File: rtl/ai_accel_pkg.sv
// rtl/ai_accel_pkg.sv - shared constants and types for the accelerator datapath
package ai_accel_pkg;

   localparam int DATA_W    = 64;
   localparam int TILE_ROWS = 8;

   // Bit positions inside data_in_buffer.overrun_err
   localparam int OVR_W_BIT = 1;
   localparam int OVR_I_BIT = 0;

   typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through FIFO with a separate occupancy counter
// A push into a full FIFO is taken only when a pop frees the slot in the same cycle.
module sync_fifo #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 16
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [DATA_W-1:0]      din,
   output logic [DATA_W-1:0]      dout,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty,
   output logic                   overrun
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && !flush && (!full || do_pop);
   assign overrun = push && !flush && full && !do_pop;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      end else if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/data_in_buffer.sv
// rtl/data_in_buffer.sv - steers pushed words into weight/input FIFOs and reports status
// DIB_ERR_STICKY_EN: overrun_err bits hold until flush/reset instead of pulsing one cycle.
module data_in_buffer #(
   parameter int DATA_W    = ai_accel_pkg::DATA_W,
   parameter int DEPTH     = 16,
   parameter int TILE_ROWS = ai_accel_pkg::TILE_ROWS
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic                   wr_en_push,
   input  logic                   is_weight,
   input  logic [DATA_W-1:0]      write_data,
   input  logic                   flush,
   output logic [DATA_W-1:0]      w_data,
   output logic                   w_valid,
   input  logic                   w_ready,
   output logic [DATA_W-1:0]      i_data,
   output logic                   i_valid,
   input  logic                   i_ready,
   output logic [$clog2(DEPTH):0] w_count,
   output logic [$clog2(DEPTH):0] i_count,
   output logic                   weights_loaded,
   output logic                   buf_full,
   output logic [1:0]             overrun_err
);

   import ai_accel_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] TILE_CNT = CW'(TILE_ROWS);

   logic       w_push, i_push;
   logic       w_full, i_full;
   logic       w_empty, i_empty;
   logic       w_ovr, i_ovr;
   logic [1:0] ovr_now;

   assign w_push = wr_en_push && is_weight;
   assign i_push = wr_en_push && !is_weight;

   sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_w_fifo (
      .clk     (clk),
      .n_rst   (n_rst),
      .push    (w_push),
      .pop     (w_valid && w_ready),
      .flush   (flush),
      .din     (write_data),
      .dout    (w_data),
      .count   (w_count),
      .full    (w_full),
      .empty   (w_empty),
      .overrun (w_ovr)
   );

   sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_i_fifo (
      .clk     (clk),
      .n_rst   (n_rst),
      .push    (i_push),
      .pop     (i_valid && i_ready),
      .flush   (flush),
      .din     (write_data),
      .dout    (i_data),
      .count   (i_count),
      .full    (i_full),
      .empty   (i_empty),
      .overrun (i_ovr)
   );

   assign w_valid        = !w_empty;
   assign i_valid        = !i_empty;
   assign weights_loaded = (w_count >= TILE_CNT);
   assign buf_full       = w_full || i_full;

   always_comb begin
      ovr_now            = '0;
      ovr_now[OVR_W_BIT] = w_ovr;
      ovr_now[OVR_I_BIT] = i_ovr;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         overrun_err <= '0;
      end else if (flush) begin
         overrun_err <= '0;
      end else begin
`ifdef DIB_ERR_STICKY_EN
         overrun_err <= overrun_err | ovr_now;
`else
         overrun_err <= ovr_now;
`endif
      end
   end

endmodule

// File: tb/tb_data_in_buffer.sv
// tb/tb_data_in_buffer.sv - self-checking bench for data_in_buffer against a queue model
// Honours DIB_ERR_STICKY_EN to select sticky or pulse expectations for overrun_err.
module tb_data_in_buffer;

   localparam int DW    = 64;
   localparam int DEPTH = 16;
   localparam int TILE  = 8;
   localparam int CW    = 5;

   logic          clk = 1'b0;
   logic          n_rst;
   logic          wr_en_push, is_weight, flush, w_ready, i_ready;
   logic [DW-1:0] write_data;
   logic [DW-1:0] w_data, i_data;
   logic          w_valid, i_valid, weights_loaded, buf_full;
   logic [CW-1:0] w_count, i_count;
   logic [1:0]    overrun_err;

   logic [DW-1:0] wq[$];
   logic [DW-1:0] iq[$];
   logic [1:0]    err_m;
   int            pass_cnt = 0;
   int            total    = 0;

   data_in_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .TILE_ROWS(TILE)) dut (
      .clk(clk), .n_rst(n_rst), .wr_en_push(wr_en_push), .is_weight(is_weight),
      .write_data(write_data), .flush(flush), .w_data(w_data), .w_valid(w_valid),
      .w_ready(w_ready), .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready),
      .w_count(w_count), .i_count(i_count), .weights_loaded(weights_loaded),
      .buf_full(buf_full), .overrun_err(overrun_err)
   );

   always #5 clk = ~clk;

   // One clock cycle of stimulus; the model applies the buffer's rules to the queues.
   task automatic step(input logic p, input logic isw, input logic [DW-1:0] d,
                       input logic wr, input logic ir, input logic fl);
      logic pop_w, pop_i;
      logic [1:0] drop;
      wr_en_push = p; is_weight = isw; write_data = d; w_ready = wr; i_ready = ir; flush = fl;
      @(posedge clk);
      pop_w = wr && (wq.size() > 0);
      pop_i = ir && (iq.size() > 0);
      drop  = 2'b00;
      if (fl) begin
         wq.delete(); iq.delete(); err_m = 2'b00;
      end else begin
         if (pop_w) void'(wq.pop_front());
         if (pop_i) void'(iq.pop_front());
         if (p && isw)  begin if (wq.size() < DEPTH) wq.push_back(d); else drop[1] = 1'b1; end
         if (p && !isw) begin if (iq.size() < DEPTH) iq.push_back(d); else drop[0] = 1'b1; end
`ifdef DIB_ERR_STICKY_EN
         err_m = err_m | drop;
`else
         err_m = drop;
`endif
      end
      #1;
      wr_en_push = 0; flush = 0; w_ready = 0; i_ready = 0;
   endtask

   task automatic test_reset;
      n_rst = 0; wr_en_push = 0; is_weight = 0; write_data = '0; flush = 0; w_ready = 0; i_ready = 0;
      err_m = 2'b00;
      #3;
      total++; if (w_valid !== 1'b0 || i_valid !== 1'b0) $display("FAIL reset_valid got w=%b i=%b want 0", w_valid, i_valid); else pass_cnt++;
      total++; if (w_count !== '0 || i_count !== '0) $display("FAIL reset_count got w=%0d i=%0d want 0", w_count, i_count); else pass_cnt++;
      total++; if (weights_loaded !== 1'b0 || buf_full !== 1'b0 || overrun_err !== 2'b00) $display("FAIL reset_flags got wl=%b bf=%b ov=%b want 0", weights_loaded, buf_full, overrun_err); else pass_cnt++;
      total++; if (w_data !== '0 || i_data !== '0) $display("FAIL reset_data got w=%h i=%h want 0", w_data, i_data); else pass_cnt++;
      @(negedge clk); n_rst = 1;
   endtask

   task automatic test_reset_mid;
      for (int k = 0; k < 3; k++) step(1, 1, 64'h5000 + DW'(k), 0, 0, 0);
      for (int k = 0; k < 2; k++) step(1, 0, 64'h6000 + DW'(k), 0, 0, 0);
      @(negedge clk); n_rst = 0; #1;
      total++; if (w_count !== '0 || i_count !== '0 || w_valid !== 1'b0 || w_data !== '0) $display("FAIL reset_mid got wc=%0d ic=%0d wv=%b wd=%h want 0", w_count, i_count, w_valid, w_data); else pass_cnt++;
      wr_en_push = 1; is_weight = 1; write_data = 64'hFFFF;
      @(posedge clk); #1;
      wr_en_push = 0;
      @(negedge clk); n_rst = 1;
      wq.delete(); iq.delete(); err_m = 2'b00;
      #1;
      total++; if (w_count !== '0 || w_valid !== 1'b0) $display("FAIL reset_push_dropped got wc=%0d wv=%b want 0", w_count, w_valid); else pass_cnt++;
   endtask

   task automatic test_weight_basic;
      step(1, 1, 64'h1111_1111_1111_1111, 0, 0, 0);
      step(1, 1, 64'h2222_2222_2222_2222, 0, 0, 0);
      step(1, 1, 64'h3333_3333_3333_3333, 0, 0, 0);
      total++; if (w_count !== 5'd3) $display("FAIL basic_count got %0d want 3", w_count); else pass_cnt++;
      total++; if (w_data !== 64'h1111_1111_1111_1111) $display("FAIL basic_head got %h want 1111111111111111", w_data); else pass_cnt++;
      total++; if (i_valid !== 1'b0) $display("FAIL basic_i_valid got %b want 0", i_valid); else pass_cnt++;
      total++; if (w_data !== 64'h1111_1111_1111_1111) $display("FAIL basic_pop0 got %h", w_data); else pass_cnt++;
      step(0, 0, '0, 1, 0, 0);
      total++; if (w_data !== 64'h2222_2222_2222_2222) $display("FAIL basic_pop1 got %h want 2222222222222222", w_data); else pass_cnt++;
      step(0, 0, '0, 1, 0, 0);
      total++; if (w_data !== 64'h3333_3333_3333_3333) $display("FAIL basic_pop2 got %h want 3333333333333333", w_data); else pass_cnt++;
      step(0, 0, '0, 1, 0, 0);
      total++; if (w_valid !== 1'b0 || w_count !== '0) $display("FAIL basic_empty got wv=%b wc=%0d want 0", w_valid, w_count); else pass_cnt++;
   endtask

   task automatic test_tile_ready;
      for (int k = 0; k < TILE; k++) begin
         step(1, 1, 64'h7000 + DW'(k), 0, 0, 0);
         total++; if (weights_loaded !== (k == TILE - 1)) $display("FAIL tile_loaded push%0d got %b want %b", k + 1, weights_loaded, k == TILE - 1); else pass_cnt++;
      end
      step(0, 0, '0, 1, 0, 0);
      total++; if (weights_loaded !== 1'b0 || w_count !== 5'd7) $display("FAIL tile_after_pop got wl=%b wc=%0d want 0/7", weights_loaded, w_count); else pass_cnt++;
      step(0, 0, '0, 0, 0, 1);
   endtask

   task automatic test_overrun;
      logic [1:0] idle_exp;
`ifdef DIB_ERR_STICKY_EN
      idle_exp = 2'b01;
`else
      idle_exp = 2'b00;
`endif
      for (int k = 0; k < DEPTH; k++) step(1, 0, 64'hA000 + DW'(k), 0, 0, 0);
      total++; if (i_count !== 5'd16 || buf_full !== 1'b1) $display("FAIL ovr_fill got ic=%0d bf=%b want 16/1", i_count, buf_full); else pass_cnt++;
      step(1, 0, 64'hDEAD, 0, 0, 0);
      total++; if (overrun_err !== 2'b01) $display("FAIL ovr_i_err got %b want 01", overrun_err); else pass_cnt++;
      total++; if (i_count !== 5'd16 || i_data !== 64'hA000) $display("FAIL ovr_i_keep got ic=%0d id=%h want 16/a000", i_count, i_data); else pass_cnt++;
      step(0, 0, '0, 0, 0, 0);
      total++; if (overrun_err !== idle_exp) $display("FAIL ovr_idle got %b want %b", overrun_err, idle_exp); else pass_cnt++;
      step(0, 0, '0, 0, 0, 1);
      total++; if (overrun_err !== 2'b00) $display("FAIL ovr_flush_clear got %b want 00", overrun_err); else pass_cnt++;
      for (int k = 0; k < DEPTH; k++) step(1, 0, 64'hB000 + DW'(k), 0, 0, 0);
      step(1, 0, 64'hBEEF, 0, 1, 0);
      total++; if (i_count !== 5'd16 || overrun_err !== 2'b00 || i_data !== 64'hB001) $display("FAIL ovr_pop_accept got ic=%0d ov=%b id=%h want 16/00/b001", i_count, overrun_err, i_data); else pass_cnt++;
      step(0, 0, '0, 0, 0, 1);
      for (int k = 0; k < DEPTH; k++) step(1, 1, 64'hC000 + DW'(k), 0, 0, 0);
      step(1, 1, 64'hDEAD, 0, 0, 0);
      total++; if (overrun_err !== 2'b10 || w_count !== 5'd16) $display("FAIL ovr_w_err got ov=%b wc=%0d want 10/16", overrun_err, w_count); else pass_cnt++;
      step(0, 0, '0, 0, 0, 1);
   endtask

   task automatic test_interleave;
      step(1, 1, 64'hE001, 0, 0, 0);
      step(1, 0, 64'hF001, 0, 0, 0);
      step(1, 1, 64'hE002, 0, 0, 0);
      step(1, 0, 64'hF002, 0, 0, 0);
      total++; if (w_count !== 5'd2 || i_count !== 5'd2) $display("FAIL inter_count got wc=%0d ic=%0d want 2/2", w_count, i_count); else pass_cnt++;
      total++; if (w_data !== 64'hE001 || i_data !== 64'hF001) $display("FAIL inter_head0 got w=%h i=%h want e001/f001", w_data, i_data); else pass_cnt++;
      step(0, 0, '0, 1, 1, 0);
      total++; if (w_data !== 64'hE002 || i_data !== 64'hF002) $display("FAIL inter_head1 got w=%h i=%h want e002/f002", w_data, i_data); else pass_cnt++;
      step(0, 0, '0, 1, 1, 0);
   endtask

   task automatic test_flush;
      for (int k = 0; k < 5; k++) step(1, 1, 64'h9000 + DW'(k), 0, 0, 0);
      step(1, 1, 64'h9999, 0, 0, 1);
      total++; if (w_count !== '0 || i_count !== '0 || w_valid !== 1'b0 || i_valid !== 1'b0) $display("FAIL flush_state got wc=%0d ic=%0d wv=%b iv=%b want 0", w_count, i_count, w_valid, i_valid); else pass_cnt++;
      total++; if (overrun_err !== 2'b00) $display("FAIL flush_err got %b want 00", overrun_err); else pass_cnt++;
   endtask

   task automatic test_wrap;
      logic [DW-1:0] base;
      base = {$urandom, $urandom};
      step(1, 0, base, 0, 1, 0);
      for (int k = 1; k < 40; k++) begin
         total++; if (i_data !== base + DW'(k - 1)) $display("FAIL wrap_data k=%0d got %h want %h", k, i_data, base + DW'(k - 1)); else pass_cnt++;
         step(1, 0, base + DW'(k), 0, 1, 0);
         total++; if (i_count !== 5'd1) $display("FAIL wrap_count k=%0d got %0d want 1", k, i_count); else pass_cnt++;
      end
      step(0, 0, '0, 0, 1, 0);
      total++; if (i_valid !== 1'b0) $display("FAIL wrap_drain got %b want 0", i_valid); else pass_cnt++;
   endtask

   task automatic test_random;
      logic p, isw, wr, ir, fl;
      for (int n = 0; n < 400; n++) begin
         p   = ($urandom_range(3) != 0);
         isw = $urandom_range(1);
         wr  = (n < 200) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
         ir  = (n < 200) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
         fl  = ($urandom_range(39) == 0);
         step(p, isw, {$urandom, $urandom}, wr, ir, fl);
         total++; if (w_count !== CW'(wq.size()) || i_count !== CW'(iq.size())) $display("FAIL rand_count n=%0d got wc=%0d ic=%0d want %0d/%0d", n, w_count, i_count, wq.size(), iq.size()); else pass_cnt++;
         total++; if (w_valid !== (wq.size() > 0) || i_valid !== (iq.size() > 0)) $display("FAIL rand_valid n=%0d got wv=%b iv=%b", n, w_valid, i_valid); else pass_cnt++;
         if (wq.size() > 0) begin total++; if (w_data !== wq[0]) $display("FAIL rand_w_data n=%0d got %h want %h", n, w_data, wq[0]); else pass_cnt++; end
         if (iq.size() > 0) begin total++; if (i_data !== iq[0]) $display("FAIL rand_i_data n=%0d got %h want %h", n, i_data, iq[0]); else pass_cnt++; end
         total++; if (weights_loaded !== (wq.size() >= TILE)) $display("FAIL rand_loaded n=%0d got %b", n, weights_loaded); else pass_cnt++;
         total++; if (buf_full !== (wq.size() == DEPTH || iq.size() == DEPTH)) $display("FAIL rand_full n=%0d got %b", n, buf_full); else pass_cnt++;
         total++; if (overrun_err !== err_m) $display("FAIL rand_err n=%0d got %b want %b", n, overrun_err, err_m); else pass_cnt++;
      end
   endtask

   initial begin
      test_reset;
      test_reset_mid;
      test_weight_basic;
      test_tile_ready;
      test_overrun;
      test_interleave;
      test_flush;
      test_wrap;
      test_random;
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
